cordic_tanh_div: RTL
====================

Name: cordic_tanh_div

Overview:
- Downstream consumer of the 8-bit hyperbolic CORDIC pipeline.
- Takes the rotated vector (Xn = K·cosh z, Yn = K·sinh z, both XY_SZ+1-bit signed) and forms tanh(z) = Yn/Xn. The CORDIC gain K cancels in the ratio.
- Uses a multi-cycle restoring divider with valid/ready handshakes on both sides.
- Output feeds the activation-function result path as a signed fixed-point fraction.

Parameters:
- XY_SZ, 8: CORDIC data width. Input operands are XY_SZ+1 bits signed.
- FRAC_BITS, 7: quotient fractional bits; equals the number of divider iterations.
- OUT_W, FRAC_BITS+1: output width; signed Q0.FRAC_BITS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- x_in  in  XY_SZ+1  signed cosh term (Xout of CORDIC).
- y_in  in  XY_SZ+1  signed sinh term (Yout of CORDIC).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_W  signed tanh, Q0.FRAC_BITS.
- out_err  out  1  x_in was ≤ 0 (invalid denominator).

Behaviour:
- Reset (async, active-high):
  - state=IDLE, out_valid=0, out_data=0, out_err=0.
  - in_ready=0 while rst is high.
  - Internal registers cleared.
  - Reset mid-operation abandons the division; no output is produced.
- FSM states:
  - IDLE: in_ready=1.
  - DIV: FRAC_BITS cycles.
  - DONE: out_valid=1.
- in_ready is high only in IDLE (not during rst). There is no accept in DIV or DONE.
- Accept edge (IDLE, in_valid=1):
  - Latch sign s = y_in[MSB], magnitude |y_in| (XY_SZ+1 bits unsigned; -2^XY_SZ is representable), and d = x_in.
  - If x_in ≤ 0: go to DONE with out_data=0, out_err=1.
  - Else if |y_in| ≥ x_in: saturate. Go to DONE with out_data = +(2^FRAC_BITS−1), or −(2^FRAC_BITS−1) if s=1; out_err=0.
  - Else: rem=|y_in|, q=0, go to DIV.
- DIV iteration (one per cycle, MSB first):
  - rem2 = rem<<1. If rem2 ≥ d then rem = rem2−d and the q bit is 1; otherwise rem = rem2 and the q bit is 0.
  - rem is XY_SZ+2 bits wide so 2·d does not overflow.
- After FRAC_BITS iterations, in the same edge:
  - out_data = s ? −q : q (two's complement, truncated toward zero); out_err=0; state = DONE.
  - y_in=0 yields 0; negative zero is impossible.
- Latency:
  - Normal path: out_valid visible after the FRAC_BITS-th edge following the accept edge.
  - Saturate and error paths: out_valid visible after the accept edge.
- DONE:
  - out_data, out_err and out_valid are held stable while out_ready=0.
  - On out_valid && out_ready: out_valid→0 at that edge, state→IDLE.
  - out_data keeps its last value after the handshake.
- Throughput: at most one result per FRAC_BITS+2 cycles on the normal path.
- in_valid asserted outside IDLE is ignored; the upstream side must hold it until in_ready.
- |out_data| ≤ 2^FRAC_BITS−1. Value −2^FRAC_BITS is never produced.

Optional Feature:
- Macro: CORDIC_TANH_SIGMOID_OUT_EN.
- When defined, the final stage converts the result to sigmoid: out_data = (t + 2^FRAC_BITS) >> 1, where t is the signed tanh result.
  - This computes σ(2z) = (1+tanh z)/2.
  - out_data is then unsigned, range 0 .. 2^FRAC_BITS−1.
  - The conversion applies to the normal and saturate paths. The error path still outputs 0.
  - Latency is unchanged; the conversion is done in the same edge that enters DONE.
- When not defined, out_data is signed tanh as above.

Test Plan:
- Positive ratio: x_in=100, y_in=50 → after 7 DIV cycles out_data=8'h40 (64), out_err=0. With SIGMOID: 8'h60 (96).
- Negative ratio: x_in=100, y_in=−50 → out_data=8'hC0 (−64). With SIGMOID: 8'h20 (32).
- Saturation: (x=100, y=100) → 8'h7F; (x=100, y=−120) → 8'h81. Both give out_valid one edge after accept. With SIGMOID: 127 and 0.
- Error: x_in=0, y_in=10 → out_err=1, out_data=0; x_in=−5 likewise.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data stable, in_ready=0, in_valid pulses ignored. Raise out_ready → out_valid drops next edge, in_ready=1.
- Reset mid-DIV: assert rst 3 cycles after accept → out_valid=0 and out_data=0 immediately (async). After release, state is IDLE and a fresh (x=64, y=32) gives 8'h40.

Source files
------------

// File: rtl/cordic_tanh_div.sv
// cordic_tanh_div
//   Forms tanh(z) = Yn / Xn from the rotated vector of the hyperbolic CORDIC.
//   The CORDIC gain cancels in the ratio. A restoring divider produces one
//   quotient bit per cycle, MSB first, with valid/ready handshakes on both sides.
//
//   Optional build macro: CORDIC_TANH_SIGMOID_OUT_EN
//     When defined, the value entering DONE is converted to sigmoid,
//     (t + 2^FRAC_BITS) >> 1, which is unsigned 0 .. 2^FRAC_BITS-1.
//     The error path still outputs 0.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE only, never during rst)
//   x_in       signed cosh term, XY_SZ+1 bits
//   y_in       signed sinh term, XY_SZ+1 bits
//   out_valid  result valid (DONE)
//   out_ready  downstream accepts result
//   out_data   tanh as signed Q0.FRAC_BITS, or sigmoid when the macro is set
//   out_err    x_in was <= 0
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready=1
// DIV   | restoring division, FRAC_BITS cycles
// DONE  | result presented, out_valid=1 until out_ready
module cordic_tanh_div #(
    parameter int XY_SZ     = 8,
    parameter int FRAC_BITS = 7,
    parameter int OUT_W     = FRAC_BITS + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XY_SZ:0]   x_in,
    input  logic [XY_SZ:0]   y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    localparam int CNT_W = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;
    localparam int REM_W = XY_SZ + 2;

    localparam logic [OUT_W-1:0] SAT_POS = OUT_W'((1 << FRAC_BITS) - 1);
    localparam logic [OUT_W-1:0] SAT_NEG = OUT_W'(-((1 << FRAC_BITS) - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [REM_W-1:0]     rem_q;
    logic [FRAC_BITS-1:0] q_q;
    logic [XY_SZ-1:0]     d_q;
    logic                 s_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 accept;
    logic [XY_SZ:0]       y_mag;
    logic                 x_bad;
    logic                 y_sat;
    logic [REM_W-1:0]     rem2;
    logic [REM_W-1:0]     d_ext;
    logic                 q_bit;
    logic [FRAC_BITS-1:0] q_next;
    logic [OUT_W-1:0]     q_signed;
    logic                 last_iter;

    // Final-stage conversion shared by the normal and saturate paths.
    function automatic logic [OUT_W-1:0] finalize(input logic [OUT_W-1:0] t);
`ifdef CORDIC_TANH_SIGMOID_OUT_EN
        logic [OUT_W:0] sum;
        sum = {t[OUT_W-1], t} + (OUT_W+1)'(1 << FRAC_BITS);
        return OUT_W'(sum >> 1);
`else
        return t;
`endif
    endfunction

    // -2^XY_SZ maps to 2^XY_SZ, which still fits in XY_SZ+1 unsigned bits.
    assign y_mag  = y_in[XY_SZ] ? (~y_in + 1'b1) : y_in;
    assign x_bad  = x_in[XY_SZ] || (x_in == '0);
    assign y_sat  = (y_mag >= {1'b0, x_in[XY_SZ-1:0]});
    assign accept = in_ready && in_valid;

    // rem < d throughout, so the doubled remainder never reaches the top bit.
    assign rem2      = rem_q << 1;
    assign d_ext     = {2'b00, d_q};
    assign q_bit     = (rem2 >= d_ext);
    assign q_next    = {q_q[FRAC_BITS-2:0], q_bit};
    assign q_signed  = s_q ? -{1'b0, q_next} : {1'b0, q_next};
    assign last_iter = (cnt_q == '0);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (x_bad || y_sat) state_d = DONE;
                    else                state_d = DIV;
                end
            end
            DIV: begin
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = !rst;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // divider datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            q_q      <= '0;
            d_q      <= '0;
            s_q      <= 1'b0;
            cnt_q    <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        s_q   <= y_in[XY_SZ];
                        d_q   <= x_in[XY_SZ-1:0];
                        rem_q <= {1'b0, y_mag};
                        q_q   <= '0;
                        cnt_q <= CNT_W'(FRAC_BITS - 1);
                        if (x_bad) begin
                            out_data <= '0;
                            out_err  <= 1'b1;
                        end else if (y_sat) begin
                            out_data <= finalize(y_in[XY_SZ] ? SAT_NEG : SAT_POS);
                            out_err  <= 1'b0;
                        end
                    end
                end
                DIV: begin
                    rem_q <= q_bit ? (rem2 - d_ext) : rem2;
                    q_q   <= q_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (last_iter) begin
                        out_data <= finalize(q_signed);
                        out_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
